bus_slave_port: RTL and testbench

- Slave-side responder for the serial 1-bit system bus. It is instantiated once per slave (s1/s2/s3) behind the bus arbiter.
- It deserialises the address and write data that the arbiter forwards from the connected master, and performs the access on a local memory.
- It serialises read data back to the master.
- It drives ready/hold so the arbiter can start transactions and split long reads.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/slave_mem.sv | 40 ++++
 rtl/bus_slave_port.sv | 198 +++++++++++++++++++
 tb/tb_bus_slave_port.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
//   Shared definitions for the serial 1-bit system bus (master, arbiter and
//   slave blocks).
//   - bus_state_t    : slave-port transaction states
//   - BUS_ADDR_WIDTH : default slave-local address width
//   - BUS_DATA_WIDTH : default data word width
//   - BUS_MSB_FIRST  : serial bit order used on every bus lane
// -----------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WRITE = 3'd3,
    RWAIT = 3'd4,
    RDATA = 3'd5
  } bus_state_t;

  localparam int unsigned BUS_ADDR_WIDTH = 12;
  localparam int unsigned BUS_DATA_WIDTH = 8;
  localparam bit          BUS_MSB_FIRST  = 1'b1;

endpackage

// File: rtl/slave_mem.sv
// -----------------------------------------------------------------------------
// slave_mem
//   Single-port synchronous RAM, 2^ADDR_WIDTH x DATA_WIDTH, registered read.
//   Contents are not reset.
//   Ports:
//     clk    in   clock
//     we     in   write enable (mem[addr] <= wdata)
//     re     in   read enable  (rdata <= mem[addr])
//     addr   in   word address
//     wdata  in   write data
//     rdata  out  registered read data, held while re=0
// -----------------------------------------------------------------------------
module slave_mem
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_slave_port.sv
// -----------------------------------------------------------------------------
// bus_slave_port
//   Slave-side responder for the serial 1-bit system bus. Deserialises the
//   address (and write data) forwarded by the arbiter, performs the access on
//   a local slave_mem, and serialises read data back to the master.
//   Ports:
//     clk        in   system clock
//     reset      in   asynchronous, active-low reset
//     address    in   serial address bit, MSB first
//     data       in   serial write-data bit, MSB first
//     valid      in   qualifies address/data this cycle
//     write_en   in   1 = write, 0 = read; sampled with the first address bit
//     bus_ready  in   bus path free; 0 stalls bit transfer in both directions
//     ready      out  idle and able to accept a new transaction
//     data_out   out  serial read-data bit, MSB first (registered)
//     valid_out  out  qualifies data_out (registered)
//     hold       out  busy in read latency, arbiter may switch masters
// -----------------------------------------------------------------------------
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = BUS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = BUS_DATA_WIDTH,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic address,
  input  logic data,
  input  logic valid,
  input  logic write_en,
  input  logic bus_ready,
  output logic ready,
  output logic data_out,
  output logic valid_out,
  output logic hold
);

  localparam int unsigned CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned LAT_W   = $clog2(READ_LATENCY + 1);

  bus_state_t state;
  bus_state_t state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic [LAT_W-1:0]      lat_cnt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [DATA_WIDTH-1:0] wdata_sr;
  logic [DATA_WIDTH-1:0] wdata_shift;
  logic [DATA_WIDTH-1:0] rd_sr;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  wen_l;
  logic                  wen_eff;
  logic                  accept;
  logic                  addr_phase;
  logic                  addr_last;
  logic                  data_last;
  logic                  lat_last;
  logic                  rd_bit;
  logic                  mem_we;
  logic                  mem_re;

  assign accept     = valid & bus_ready;
  assign addr_phase = (state == IDLE) || (state == ADDR);
  // cnt is 0 in IDLE, so the same compare covers ADDR_WIDTH==1 straight from IDLE
  assign addr_last  = (cnt == CNT_W'(ADDR_WIDTH - 1));
  assign data_last  = (cnt == CNT_W'(DATA_WIDTH - 1));
  assign lat_last   = (lat_cnt == LAT_W'(READ_LATENCY - 1));
  assign wen_eff    = (state == IDLE) ? write_en : wen_l;

  assign addr_shift  = BUS_MSB_FIRST ? ((addr_sr << 1) | ADDR_WIDTH'(address))
                                     : ((addr_sr >> 1) | (ADDR_WIDTH'(address) << (ADDR_WIDTH - 1)));
  assign wdata_shift = BUS_MSB_FIRST ? ((wdata_sr << 1) | DATA_WIDTH'(data))
                                     : ((wdata_sr >> 1) | (DATA_WIDTH'(data) << (DATA_WIDTH - 1)));
  assign rd_shift    = BUS_MSB_FIRST ? (rd_sr << 1) : (rd_sr >> 1);
  assign rd_bit      = BUS_MSB_FIRST ? rd_sr[DATA_WIDTH-1] : rd_sr[0];

  assign ready = reset && (state == IDLE);
  assign hold  = (state == RWAIT);

  // The read is launched on the edge that takes the last address bit, using the
  // address as it is being completed, so rdata is stable for the whole RWAIT
  // window and READ_LATENCY=1 still has data ready at the RWAIT->RDATA edge.
  assign mem_we   = (state == WRITE);
  assign mem_re   = addr_phase && accept && addr_last && !wen_eff;
  assign mem_addr = mem_we ? addr_sr : addr_shift;

  slave_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (wdata_sr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ADDR: begin
        if (accept) begin
          if (addr_last) begin
            state_nxt = wen_eff ? WDATA : RWAIT;
          end else begin
            state_nxt = ADDR;
          end
        end
      end
      WDATA: begin
        if (accept && data_last) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
      end
      RWAIT: begin
        if (lat_last) begin
          state_nxt = RDATA;
        end
      end
      RDATA: begin
        if (bus_ready && data_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      lat_cnt   <= '0;
      addr_sr   <= '0;
      wdata_sr  <= '0;
      rd_sr     <= '0;
      wen_l     <= 1'b0;
      data_out  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE, ADDR: begin
          if (accept) begin
            addr_sr <= addr_shift;
            lat_cnt <= '0;
            cnt     <= addr_last ? '0 : cnt + CNT_W'(1);
            if (state == IDLE) begin
              wen_l <= write_en;
            end
          end
        end
        WDATA: begin
          if (accept) begin
            wdata_sr <= wdata_shift;
            cnt      <= data_last ? '0 : cnt + CNT_W'(1);
          end
        end
        RWAIT: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          if (lat_last) begin
            rd_sr <= mem_rdata;
            cnt   <= '0;
          end
        end
        RDATA: begin
          if (bus_ready) begin
            data_out  <= rd_bit;
            valid_out <= 1'b1;
            rd_sr     <= rd_shift;
            cnt       <= data_last ? '0 : cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave_port.sv
module tb_bus_slave_port;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i[2], addr_i[2], data_i[2], valid_i[2], we_i[2], br_i[2];
  logic rdy_o[2], dout_o[2], vout_o[2], hold_o[2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) dut0 (
    .clk(clk), .reset(rst_i[0]), .address(addr_i[0]), .data(data_i[0]),
    .valid(valid_i[0]), .write_en(we_i[0]), .bus_ready(br_i[0]),
    .ready(rdy_o[0]), .data_out(dout_o[0]), .valid_out(vout_o[0]), .hold(hold_o[0])
  );

  bus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(5)) dut1 (
    .clk(clk), .reset(rst_i[1]), .address(addr_i[1]), .data(data_i[1]),
    .valid(valid_i[1]), .write_en(we_i[1]), .bus_ready(br_i[1]),
    .ready(rdy_o[1]), .data_out(dout_o[1]), .valid_out(vout_o[1]), .hold(hold_o[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 5;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", name, k, cyc, got, exp);
    end
  endtask

  // Transaction-level reference: bits collected, write committed a cycle
  // later, read word emitted after a fixed wait, one bit per bus_ready cycle.
  int         rx_bits[2];
  int         wait_left[2];
  int         out_left[2];
  bit         commit[2];
  bit         m_wr[2];
  logic [11:0] m_addr[2];
  logic [7:0]  m_wd[2];
  logic [7:0]  m_word[2];
  logic [7:0]  mm[2][4096];
  bit         e_vout[2];
  bit         e_dout[2];

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      e_vout[k] = 1'b0;
      if (!rst_i[k]) begin
        rx_bits[k] = 0; wait_left[k] = 0; out_left[k] = 0; commit[k] = 1'b0;
        e_dout[k] = 1'b0;
      end else if (out_left[k] > 0) begin
        if (br_i[k]) begin
          e_dout[k] = m_word[k][out_left[k]-1];
          e_vout[k] = 1'b1;
          out_left[k]--;
        end
      end else if (wait_left[k] > 0) begin
        wait_left[k]--;
        if (wait_left[k] == 0) begin
          m_word[k]   = mm[k][m_addr[k]];
          out_left[k] = DW;
        end
      end else if (commit[k]) begin
        mm[k][m_addr[k]] = m_wd[k];
        commit[k] = 1'b0;
      end else if (valid_i[k] && br_i[k]) begin
        if (rx_bits[k] == 0) m_wr[k] = we_i[k];
        if (rx_bits[k] < AW) m_addr[k] = {m_addr[k][10:0], addr_i[k]};
        else                 m_wd[k]   = {m_wd[k][6:0], data_i[k]};
        rx_bits[k]++;
        if (rx_bits[k] == AW && !m_wr[k]) begin
          rx_bits[k] = 0;
          wait_left[k] = lat(k);
        end else if (rx_bits[k] == AW + DW) begin
          rx_bits[k] = 0;
          commit[k] = 1'b1;
        end
      end
    end
  end

  logic [15:0] cap[2];
  int capn[2], hcnt[2], fv[2], lv[2];
  int last_addr_cyc[2], rdy_cyc[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_i[k]) begin
        chk("ready_rst", k, 32'(rdy_o[k]), 32'd0);
        chk("hold_rst", k, 32'(hold_o[k]), 32'd0);
        chk("valid_out_rst", k, 32'(vout_o[k]), 32'd0);
        chk("data_out_rst", k, 32'(dout_o[k]), 32'd0);
      end else begin
        chk("ready", k, 32'(rdy_o[k]),
            32'(rx_bits[k] == 0 && !commit[k] && wait_left[k] == 0 && out_left[k] == 0));
        chk("hold", k, 32'(hold_o[k]), 32'(wait_left[k] > 0));
        chk("valid_out", k, 32'(vout_o[k]), 32'(e_vout[k]));
        if (e_vout[k]) chk("data_out", k, 32'(dout_o[k]), 32'(e_dout[k]));
      end
      if (vout_o[k]) begin
        cap[k] = {cap[k][14:0], dout_o[k]};
        capn[k]++;
        if (capn[k] == 1) fv[k] = cyc;
        lv[k] = cyc;
      end
      if (hold_o[k]) hcnt[k]++;
    end
  end

  task automatic wait_ready(input int k, input bit rnd);
    int n = 0;
    while (rdy_o[k] !== 1'b1 && n < 300) begin
      if (rnd) begin
        valid_i[k] = 1'($urandom);
        addr_i[k]  = 1'($urandom);
        data_i[k]  = 1'($urandom);
        we_i[k]    = 1'($urandom);
        br_i[k]    = (($urandom % 4) != 0);
      end
      @(posedge clk); #2;
      n++;
    end
    valid_i[k] = 1'b0;
    br_i[k]    = 1'b1;
    rdy_cyc[k] = cyc;
    if (n >= 300) chk("ready_timeout", k, 32'(rdy_o[k]), 32'd1);
  endtask

  task automatic send(input int k, input bit wr, input logic [11:0] addr, input logic [7:0] wd,
                      input bit rnd, input int gap_a, input int gap_d, input int gaplen,
                      input int stop_at);
    int nbits = wr ? int'(AW + DW) : int'(AW);
    int i = 0;
    int guard = 0;
    if (stop_at > 0 && stop_at < nbits) nbits = stop_at;
    wait_ready(k, rnd);
    while (i < nbits && guard < 2000) begin
      if (i < int'(AW)) begin
        addr_i[k] = addr[AW-1-i];
        data_i[k] = 1'($urandom);
      end else begin
        addr_i[k] = 1'($urandom);
        data_i[k] = wd[AW+DW-1-i];
      end
      we_i[k]    = (i == 0) ? wr : 1'($urandom);
      valid_i[k] = rnd ? (($urandom % 4) != 0) : 1'b1;
      br_i[k]    = rnd ? (($urandom % 5) != 0) : 1'b1;
      @(posedge clk); #2;
      guard++;
      if (valid_i[k] && br_i[k]) begin
        i++;
        if (i == int'(AW)) last_addr_cyc[k] = cyc;
        if (gaplen > 0 && (i == gap_a || i == int'(AW) + gap_d)) begin
          valid_i[k] = 1'b0;
          repeat (gaplen) begin
            @(posedge clk); #2;
            chk("ready_gap", k, 32'(rdy_o[k]), 32'd0);
          end
        end
      end
    end
    valid_i[k] = 1'b0;
    br_i[k]    = 1'b1;
    if (guard >= 2000) chk("send_timeout", k, 32'(i), 32'(nbits));
  endtask

  task automatic do_read(input int k, input logic [11:0] addr, input logic [7:0] exp, input bit stall);
    int e;
    cap[k] = '0; capn[k] = 0; hcnt[k] = 0; fv[k] = 0; lv[k] = 0;
    send(k, 1'b0, addr, 8'h00, 1'b0, 0, 0, 0, 0);
    e = last_addr_cyc[k];
    if (stall) begin
      repeat (lat(k) + 3) @(posedge clk);
      #2 br_i[k] = 1'b0;
      repeat (2) @(posedge clk);
      #2 br_i[k] = 1'b1;
    end
    wait_ready(k, 1'b0);
    @(negedge clk); #1;
    chk("rd_word", k, 32'(cap[k][7:0]), 32'(exp));
    chk("rd_bits", k, 32'(capn[k]), 32'd8);
    chk("rd_latency", k, 32'(fv[k] - e), 32'(lat(k) + 1));
    chk("hold_cycles", k, 32'(hcnt[k]), 32'(lat(k)));
    chk("rd_span", k, 32'(lv[k] - fv[k]), stall ? 32'd9 : 32'd7);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  bit written[2][4096];

  initial begin
    logic [11:0] a;
    logic [7:0]  d;
    int k;
    bit wr;
    for (int j = 0; j < 2; j++) begin
      rst_i[j] = 1'b0; valid_i[j] = 1'b0; br_i[j] = 1'b1;
      addr_i[j] = 1'b0; data_i[j] = 1'b0; we_i[j] = 1'b0;
      cap[j] = '0; capn[j] = 0; hcnt[j] = 0;
    end
    repeat (2) @(posedge clk);
    #3;
    chk("reset_ready", 0, 32'(rdy_o[0]), 32'd0);
    chk("reset_valid_out", 0, 32'(vout_o[0]), 32'd0);
    chk("reset_hold", 0, 32'(hold_o[0]), 32'd0);
    @(posedge clk); #2;
    rst_i[0] = 1'b1; rst_i[1] = 1'b1;
    #1 chk("ready_after_reset", 0, 32'(rdy_o[0]), 32'd1);
    @(posedge clk); #2;

    // write / readback
    send(0, 1'b1, 12'h123, 8'hA5, 1'b0, 0, 0, 0, 0);
    do_read(0, 12'h123, 8'hA5, 1'b0);

    // valid gaps during address and data
    send(0, 1'b1, 12'hFFF, 8'h3C, 1'b0, 5, 2, 3, 0);
    wait_ready(0, 1'b0);
    chk("ready_after_write", 0, 32'(rdy_o[0]), 32'd1);
    do_read(0, 12'hFFF, 8'h3C, 1'b0);

    // bus_ready stall during read data
    send(0, 1'b1, 12'h000, 8'hF0, 1'b0, 0, 0, 0, 0);
    do_read(0, 12'h000, 8'hF0, 1'b1);

    // reset in the middle of a write
    send(0, 1'b1, 12'h010, 8'h11, 1'b0, 0, 0, 0, 0);
    send(0, 1'b1, 12'h010, 8'hFF, 1'b0, 0, 0, 0, int'(AW) + 4);
    rst_i[0] = 1'b0;
    #1;
    chk("midrst_ready", 0, 32'(rdy_o[0]), 32'd0);
    chk("midrst_valid_out", 0, 32'(vout_o[0]), 32'd0);
    chk("midrst_hold", 0, 32'(hold_o[0]), 32'd0);
    @(posedge clk); #2;
    rst_i[0] = 1'b1;
    #1 chk("midrst_ready_release", 0, 32'(rdy_o[0]), 32'd1);
    @(posedge clk); #2;
    do_read(0, 12'h010, 8'h11, 1'b0);

    // back-to-back reads
    cap[0] = '0; capn[0] = 0;
    send(0, 1'b0, 12'h123, 8'h00, 1'b0, 0, 0, 0, 0);
    wait_ready(0, 1'b0);
    a = 12'(rdy_cyc[0]);
    send(0, 1'b0, 12'hFFF, 8'h00, 1'b0, 0, 0, 0, 0);
    chk("b2b_addr_start", 0, 32'(last_addr_cyc[0] - int'(a)), 32'd12);
    wait_ready(0, 1'b0);
    @(negedge clk); #1;
    chk("b2b_words", 0, 32'(cap[0]), 32'h0000A53C);
    chk("b2b_bits", 0, 32'(capn[0]), 32'd16);

    // longer read latency instance
    send(1, 1'b1, 12'h7FE, 8'h5A, 1'b0, 0, 0, 0, 0);
    do_read(1, 12'h7FE, 8'h5A, 1'b0);

    // randomized traffic, checked cycle by cycle against the model
    for (int t = 0; t < 80; t++) begin
      k  = (t < 60) ? 0 : 1;
      a  = (($urandom % 3) == 0) ? 12'($urandom) : 12'(12'h800 + ($urandom % 16));
      d  = 8'($urandom);
      wr = (($urandom % 2) == 0) || !written[k][a];
      send(k, wr, a, d, 1'b1, 0, 0, 0, 0);
      if (wr) written[k][a] = 1'b1;
      wait_ready(k, 1'b1);
    end
    repeat (4) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
